// File: rtl/memory_if.sv
// Bus bundle for the single-port synchronous RAM: one shared address,
// separate write/read strobes, and the registered read data returned.
interface memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output address,
    output data_in,
    output write_enable,
    output read_enable,
    input  data_out
  );

  modport slave (
    input  address,
    input  data_in,
    input  write_enable,
    input  read_enable,
    output data_out
  );

endinterface

// File: rtl/memory.sv
// Single-port synchronous RAM with write-first read-during-write, a
// registered read port, and an asynchronous reset that zeroes every word.
module memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  memory_if.slave  mem_if
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Next read-data: the written word bypasses the array on a same-edge read.
  always_comb begin
    data_out_d = data_out_q;
    rd_word_s  = mem_q[mem_if.address];
    if (mem_if.read_enable) begin
      if (mem_if.write_enable) begin
        data_out_d = mem_if.data_in;
      end else begin
        data_out_d = rd_word_s;
      end
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Storage array; the whole array is flop-based so reset can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (mem_if.write_enable) begin
        mem_q[mem_if.address] <= mem_if.data_in;
      end
    end
  end

  // Registered read port; holds its value whenever read_enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= {DATA_WIDTH{1'b0}};
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign mem_if.data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: reset clearing, write/read latency, write-first
// collision, end addresses, hold behaviour and an asynchronous reset pulse.
module tb_memory;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one bus cycle, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic we, input logic re, input logic [7:0] addr,
                     input logic [15:0] din);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.address      = addr;
    bus.data_in      = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.address      = 8'h00;
    bus.data_in      = 16'hFFFF;
    #2;
    check_eq("reset_immediate", bus.data_out, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_held_ignores_rw", bus.data_out, 16'h0000);
    rst_n = 1'b1;

    cyc(1'b0, 1'b1, 8'h00, 16'h0000);
    check_eq("read0_after_reset", bus.data_out, 16'h0000);

    cyc(1'b1, 1'b0, 8'h00, 16'h1234);
    check_eq("write_only_hold", bus.data_out, 16'h0000);
    cyc(1'b0, 1'b1, 8'h00, 16'h0000);
    check_eq("read0_1234", bus.data_out, 16'h1234);

    cyc(1'b1, 1'b1, 8'h10, 16'hBEEF);
    check_eq("write_first_new_addr", bus.data_out, 16'hBEEF);
    cyc(1'b0, 1'b0, 8'h00, 16'h0000);
    check_eq("idle_hold", bus.data_out, 16'hBEEF);
    cyc(1'b0, 1'b1, 8'h10, 16'h0000);
    check_eq("collision_stored", bus.data_out, 16'hBEEF);

    cyc(1'b1, 1'b1, 8'h00, 16'h1234);
    check_eq("write_first_addr0", bus.data_out, 16'h1234);

    cyc(1'b1, 1'b0, 8'hFF, 16'hABCD);
    check_eq("write_ff_hold", bus.data_out, 16'h1234);
    cyc(1'b0, 1'b1, 8'hFF, 16'h0000);
    check_eq("read_ff", bus.data_out, 16'hABCD);
    cyc(1'b0, 1'b1, 8'h00, 16'h0000);
    check_eq("independence_addr0", bus.data_out, 16'h1234);

    cyc(1'b1, 1'b0, 8'h55, 16'hA5A5);
    cyc(1'b0, 1'b1, 8'h55, 16'h0000);
    check_eq("read_55", bus.data_out, 16'hA5A5);
    cyc(1'b0, 1'b1, 8'h00, 16'h0000);
    check_eq("read0_again", bus.data_out, 16'h1234);

    cyc(1'b0, 1'b0, 8'hFF, 16'h0000);
    cyc(1'b0, 1'b0, 8'h55, 16'h0000);
    check_eq("hold_addr_change", bus.data_out, 16'h1234);

    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_pulse", bus.data_out, 16'h0000);
    #1;
    rst_n = 1'b1;

    cyc(1'b0, 1'b1, 8'hFF, 16'h0000);
    check_eq("ff_cleared", bus.data_out, 16'h0000);
    cyc(1'b0, 1'b1, 8'h10, 16'h0000);
    check_eq("10_cleared", bus.data_out, 16'h0000);
    cyc(1'b0, 1'b1, 8'h00, 16'h0000);
    check_eq("00_cleared", bus.data_out, 16'h0000);

    cyc(1'b0, 1'b1, 8'h55, 16'h0000);
    check_eq("55_cleared", bus.data_out, 16'h0000);
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b0;
    bus.address      = 8'h20;
    bus.data_in      = 16'h1111;
    rst_n            = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h20, 16'h0000);
    check_eq("write_in_reset_dropped", bus.data_out, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
